// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute control FSM that drives the datapath
// controls and memory handshakes, with an ack timeout that traps into FAULT.
module instr_sequencer #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] op,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       PCrst,
    output logic       LPC,
    output logic       rd1,
    output logic       rd2,
    output logic       wr_contr,
    output logic       Lflag_contr,
    output logic       isJumpInstr,
    output logic       isCallInstr,
    output logic [1:0] selM1,
    output logic [1:0] selM2,
    output logic [1:0] selM3,
    output logic [1:0] fnSel,
    output logic       busy,
    output logic       halted,
    output logic       fault
);
    typedef enum logic [3:0] {
        RESET, IDLE, FETCH, DECODE, EXEC, MEM, WB, COMMIT, HALT, FAULT
    } stateT;

    stateT      state, nextState;
    logic [6:0] opReg, curOp;
    logic [7:0] waitCnt;
    logic       timedOut, inWin, inRd;
    logic       isRr, isLi, isLd, isCmp, isHalt, isJmp, isCall;

    // The opcode is only guaranteed valid in DECODE; later states use the latched copy.
    assign curOp    = (state == DECODE) ? op : opReg;
    assign isRr     = curOp[6:5] == 2'b11;
    assign isLi     = curOp[6:5] == 2'b10;
    assign isLd     = curOp[6:5] == 2'b01;
    assign isCmp    = curOp[6:3] == 4'b0000;
    assign isHalt   = curOp[6:3] == 4'b0001;
    assign isJmp    = curOp[6:3] == 4'b0010;
    assign isCall   = curOp[6:3] == 4'b0011;
    assign timedOut = waitCnt == 8'(ACK_TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RESET;
            opReg   <= '0;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            opReg   <= curOp;
            // Counts waiting cycles; any state change (entry to FETCH/MEM included) clears it.
            waitCnt <= (nextState == state && (state == FETCH || state == MEM)) ? waitCnt + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        nextState   = state;
        inWin       = state inside {DECODE, EXEC, MEM, WB, COMMIT};
        inRd        = state inside {DECODE, EXEC, MEM, WB};
        PCrst       = state == RESET;
        LPC         = state == COMMIT;
        imem_req    = state == FETCH;
        dmem_req    = state == MEM;
        rd1         = inRd && (isRr || isLd || isCmp);
        rd2         = inRd && (isRr || isCmp);
        wr_contr    = state == WB && (isRr || isLi || isLd || isCall);
        Lflag_contr = state == WB && isCmp;
        isJumpInstr = (state == WB || state == COMMIT) && isJmp;
        isCallInstr = (state == WB || state == COMMIT) && isCall;
        selM1       = !inWin ? 2'b00 : (isRr || isCmp) ? 2'b01 : isLd ? 2'b10 : 2'b00;
        selM2       = !inWin ? 2'b00 : (isRr || isCmp) ? 2'b01 : (isLi || isJmp || isCall) ? 2'b10 : 2'b00;
        selM3       = !inWin ? 2'b00 : (isRr || isLi) ? 2'b10 : isLd ? 2'b01 : 2'b00;
        fnSel       = !inWin ? 2'b00 : (isLi || isJmp || isCall) ? 2'b01 : isLd ? 2'b10 : 2'b00;
        busy        = state inside {FETCH, DECODE, EXEC, MEM, WB, COMMIT};
        halted      = state == HALT;
        fault       = state == FAULT;
        case (state)
            RESET:   nextState = IDLE;
            IDLE:    nextState = start ? FETCH : IDLE;
            FETCH:   nextState = imem_ack ? DECODE : timedOut ? FAULT : FETCH;
            DECODE:  nextState = EXEC;
            EXEC:    nextState = isHalt ? HALT : isLd ? MEM : WB;
            MEM:     nextState = dmem_ack ? WB : timedOut ? FAULT : MEM;
            WB:      nextState = COMMIT;
            COMMIT:  nextState = FETCH;
            HALT:    nextState = start ? FETCH : HALT;
            FAULT:   nextState = FAULT;
            default: nextState = RESET;
        endcase
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed stimulus with a per-phase expectation model
// derived from the instruction-class rules, plus literal pins on key outputs.
module tb_instr_sequencer;
    localparam int P_RST = 0, P_IDLE = 1, P_FET = 2, P_DEC = 3, P_EXE = 4;
    localparam int P_MEM = 5, P_WB = 6, P_COM = 7, P_HALT = 8, P_FLT = 9;

    logic clk = 0, rst = 1, start = 0, imem_ack = 0, dmem_ack = 0;
    logic [6:0] op = '0;
    logic imem_req, dmem_req, PCrst, LPC, rd1, rd2, wr_contr, Lflag_contr;
    logic isJumpInstr, isCallInstr, busy, halted, fault;
    logic [1:0] selM1, selM2, selM3, fnSel;
    logic [20:0] actv, expv;
    logic chk = 0, pinOn = 0;
    logic [1:0] pinE;
    string pinName;
    int curPh, total = 0, bad = 0;

    instr_sequencer #(.ACK_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .PCrst(PCrst), .LPC(LPC), .rd1(rd1), .rd2(rd2),
        .wr_contr(wr_contr), .Lflag_contr(Lflag_contr), .isJumpInstr(isJumpInstr),
        .isCallInstr(isCallInstr), .selM1(selM1), .selM2(selM2), .selM3(selM3), .fnSel(fnSel),
        .busy(busy), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    assign actv = {PCrst, LPC, imem_req, dmem_req, rd1, rd2, wr_contr, Lflag_contr,
                   isJumpInstr, isCallInstr, selM1, selM2, selM3, fnSel, busy, halted, fault};

    // Expected outputs for a phase, from the instruction-class tables.
    function automatic logic [20:0] model(input int ph, input logic [6:0] o);
        logic rr, li, ld, cmp, jmp, cal, win, rdp, wbp;
        logic [7:0] sel;
        rr  = o[6:5] == 2'b11;
        li  = o[6:5] == 2'b10;
        ld  = o[6:5] == 2'b01;
        cmp = o[6:3] == 4'b0000;
        jmp = o[6:3] == 4'b0010;
        cal = o[6:3] == 4'b0011;
        win = ph >= P_DEC && ph <= P_COM;
        rdp = ph >= P_DEC && ph <= P_WB;
        wbp = ph == P_WB;
        sel = rr ? 8'b01_01_10_00 : li ? 8'b00_10_10_01 : ld ? 8'b10_00_01_10 :
              cmp ? 8'b01_01_00_00 : (jmp || cal) ? 8'b00_10_00_01 : 8'b0;
        return {ph == P_RST, ph == P_COM, ph == P_FET, ph == P_MEM,
                rdp && (rr || ld || cmp), rdp && (rr || cmp),
                wbp && (rr || li || ld || cal), wbp && cmp,
                (wbp || ph == P_COM) && jmp, (wbp || ph == P_COM) && cal,
                win ? sel : 8'b0, ph >= P_FET && ph <= P_COM, ph == P_HALT, ph == P_FLT};
    endfunction

    function automatic logic [1:0] pinAct(input string n);
        if (n == "PCrst")  return {1'b0, PCrst};
        if (n == "LPC")    return {1'b0, LPC};
        if (n == "wr")     return {1'b0, wr_contr};
        if (n == "selM3")  return selM3;
        if (n == "Lflag")  return {1'b0, Lflag_contr};
        if (n == "isJump") return {1'b0, isJumpInstr};
        if (n == "isCall") return {1'b0, isCallInstr};
        if (n == "halted") return {1'b0, halted};
        if (n == "busy")   return {1'b0, busy};
        if (n == "fault")  return {1'b0, fault};
        return {1'b0, rd1};
    endfunction

    always @(negedge clk) begin
        if (chk) begin
            total++;
            if (actv !== expv) begin
                bad++;
                $display("FAIL cycle ph=%0d t=%0t act=%b exp=%b", curPh, $time, actv, expv);
            end
        end
        if (pinOn) begin
            total++;
            if (pinAct(pinName) !== pinE) begin
                bad++;
                $display("FAIL pin %s t=%0t act=%b exp=%b", pinName, $time, pinAct(pinName), pinE);
            end
        end
    end

    task automatic pin(input string n, input logic [1:0] e);
        pinName = n;
        pinE = e;
        pinOn = 1;
    endtask

    task automatic cyc(input int ph);
        curPh = ph;
        expv = model(ph, op);
        chk = 1;
        @(posedge clk);
        #1;
        rst = 0; start = 0; imem_ack = 0; dmem_ack = 0; pinOn = 0;
    endtask

    // One instruction from FETCH entry; stray acks are driven where they must be ignored.
    task automatic runInstr(input logic [6:0] o, input int fd, input int md,
                            input string pn, input logic [1:0] pv);
        op = o;
        for (int k = 0; k <= fd; k++) begin
            imem_ack = (k == fd);
            cyc(P_FET);
        end
        imem_ack = 1; dmem_ack = 1;
        cyc(P_DEC);
        imem_ack = 1; dmem_ack = 1;
        cyc(P_EXE);
        if (o[6:3] == 4'b0001) return;
        if (o[6:5] == 2'b01)
            for (int k = 0; k <= md; k++) begin
                dmem_ack = (k == md);
                cyc(P_MEM);
            end
        imem_ack = 1; dmem_ack = 1;
        if (pn != "") pin(pn, pv);
        cyc(P_WB);
        pin("LPC", 2'b01);
        cyc(P_COM);
    endtask

    initial begin
        @(posedge clk);
        #1;
        rst = 1;
        cyc(P_RST);
        pin("PCrst", 2'b01);
        cyc(P_RST);
        imem_ack = 1;
        pin("PCrst", 2'b00);
        cyc(P_IDLE);
        start = 1;
        cyc(P_IDLE);
        runInstr(7'b1000000, 0, 0, "wr", 2'b01);
        runInstr(7'b0100000, 0, 3, "selM3", 2'b01);
        runInstr(7'b1100000, 2, 0, "rd1", 2'b01);
        runInstr(7'b0000000, 0, 0, "Lflag", 2'b01);
        runInstr(7'b0010000, 1, 0, "isJump", 2'b01);
        runInstr(7'b0011000, 0, 0, "isCall", 2'b01);
        runInstr(7'b1100000, 14, 0, "", 2'b00);
        runInstr(7'b0100111, 0, 14, "", 2'b00);
        runInstr(7'b0001000, 0, 0, "", 2'b00);
        pin("halted", 2'b01);
        cyc(P_HALT);
        imem_ack = 1; dmem_ack = 1;
        pin("busy", 2'b00);
        cyc(P_HALT);
        start = 1;
        cyc(P_HALT);
        runInstr(7'b1011111, 0, 0, "", 2'b00);
        op = 7'b0100000;
        imem_ack = 1;
        cyc(P_FET);
        cyc(P_DEC);
        cyc(P_EXE);
        cyc(P_MEM);
        rst = 1;
        cyc(P_MEM);
        dmem_ack = 1;
        pin("PCrst", 2'b01);
        cyc(P_RST);
        dmem_ack = 1;
        cyc(P_IDLE);
        cyc(P_IDLE);
        start = 1;
        cyc(P_IDLE);
        imem_ack = 1;
        cyc(P_FET);
        cyc(P_DEC);
        cyc(P_EXE);
        for (int k = 0; k < 15; k++) cyc(P_MEM);
        pin("fault", 2'b01);
        cyc(P_FLT);
        start = 1; imem_ack = 1; dmem_ack = 1;
        cyc(P_FLT);
        rst = 1;
        cyc(P_FLT);
        cyc(P_RST);
        start = 1;
        cyc(P_IDLE);
        for (int k = 0; k < 15; k++) cyc(P_FET);
        pin("fault", 2'b01);
        cyc(P_FLT);
        cyc(P_FLT);
        rst = 1;
        cyc(P_FLT);
        cyc(P_RST);
        cyc(P_IDLE);
        chk = 0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
